// File: rtl/debug_pkg.sv
// Shared types for the debug HEX display source selector.
// Mode and FSM encodings plus a small width helper.
package debug_pkg;

   typedef enum logic [1:0] {
      LIVE    = 2'd0,
      CAPTURE = 2'd1,
      FREEZE  = 2'd2,
      RSVD    = 2'd3
   } dbg_mode_t;

   typedef enum logic [1:0] {
      S_LIVE   = 2'd0,
      S_ARMED  = 2'd1,
      S_HELD   = 2'd2,
      S_FROZEN = 2'd3
   } dbg_state_t;

   function automatic int nib_count(input int w);
      return w / 4;
   endfunction

endpackage

// File: rtl/hex_window_select.sv
// Picks NUM_DIGITS nibbles out of a word starting at a nibble offset.
// Nibbles past the top of the word read as zero.
module hex_window_select
   import debug_pkg::*;
#(
   parameter int SRC_W      = 32,
   parameter int NUM_DIGITS = 6,
   parameter int OFF_W      = 4
) (
   input  logic [SRC_W-1:0]        i_word,
   input  logic [OFF_W-1:0]        i_offset,
   output logic [NUM_DIGITS*4-1:0] o_digits
);

   localparam int DIG_W = NUM_DIGITS * 4;
   localparam int PAD_W = (SRC_W > DIG_W) ? SRC_W : DIG_W;

   logic [PAD_W-1:0] w_ext;
   logic [PAD_W-1:0] w_shift;

   // Zero-extend so short words pad the upper digits with 0.
   always_comb begin
      w_ext    = PAD_W'(i_word);
      w_shift  = w_ext >> {i_offset, 2'b00};
      o_digits = w_shift[DIG_W-1:0];
   end

endmodule

// File: rtl/debug_hex_capture.sv
// Debug source selector for the board HEX digits: live,
// capture-on-strobe and freeze views with timed nibble scrolling.
module debug_hex_capture
   import debug_pkg::*;
#(
   parameter int NUM_SRC    = 8,
   parameter int SRC_W      = 32,
   parameter int NUM_DIGITS = 6,
   parameter int SCROLL_DIV = 25_000_000,
   parameter int CNT_W      = 8,
   localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [NUM_SRC*SRC_W-1:0] src_data,
   input  logic [NUM_SRC-1:0]       src_strobe,
   input  logic [SEL_W-1:0]         sel,
   input  logic [1:0]               mode,
   input  logic                     scroll_en,
   output logic [NUM_DIGITS*4-1:0]  hex_digits,
   output logic [NUM_DIGITS-1:0]    dp_n,
   output logic                     capture_valid,
   output logic [CNT_W-1:0]         capture_count
);

   localparam int NIB    = nib_count(SRC_W);
   localparam bit SCROLL = (NIB > NUM_DIGITS);
   localparam int MAXOFF = SCROLL ? (NIB - NUM_DIGITS) : 0;
   localparam int OFF_W  = $clog2(NIB + 1);
   localparam int DIV_W  = $clog2(SCROLL_DIV + 1);

   dbg_state_t          r_state;
   logic [SRC_W-1:0]    r_hold;
   logic                r_edge;
   logic [SEL_W-1:0]    r_sel;
   logic [OFF_W-1:0]    r_off;
   logic [DIV_W-1:0]    r_div;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_valid;
   logic [NUM_DIGITS*4-1:0] r_hex;
   logic [NUM_DIGITS-1:0]   r_dp;

   logic [SRC_W-1:0]    w_src;
   logic                w_stb;
   logic                w_sel_chg;
   logic                w_rise;
   dbg_state_t          w_state_nxt;
   logic [SRC_W-1:0]    w_hold_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [OFF_W-1:0]    w_off_nxt;
   logic [DIV_W-1:0]    w_div_nxt;
   logic                w_valid_nxt;
   logic [SRC_W-1:0]    w_word;
   logic [NUM_DIGITS-1:0]   w_dp_nxt;
   logic [NUM_DIGITS*4-1:0] w_digits;

   // Source mux; out-of-range selects read as zero with no strobe.
   always_comb begin
      w_src = '0;
      w_stb = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) begin
            w_src = src_data[i*SRC_W +: SRC_W];
            w_stb = src_strobe[i];
         end
      end
   end

   // Mode FSM, hold register and capture counter next state.
   always_comb begin
      w_sel_chg   = (sel != r_sel);
      w_rise      = w_stb & ~r_edge;
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_cnt_nxt   = r_cnt;
      case (dbg_mode_t'(mode))
         FREEZE: begin
            if (r_state != S_FROZEN) begin
               w_state_nxt = S_FROZEN;
               w_hold_nxt  = w_src;
            end
         end
         CAPTURE: begin
            if (r_state == S_LIVE || r_state == S_FROZEN) begin
               w_state_nxt = S_ARMED;
            end else if (w_sel_chg) begin
               w_state_nxt = S_ARMED;
            end else if (w_rise) begin
               w_state_nxt = S_HELD;
               w_hold_nxt  = w_src;
               if (r_cnt != '1) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: w_state_nxt = S_LIVE;
      endcase
      if (w_sel_chg) begin
         w_cnt_nxt = '0;
      end
      w_valid_nxt = (w_state_nxt == S_HELD);
   end

   // Scroll divider and window offset; both hold while scrolling is off.
   always_comb begin
      w_off_nxt = r_off;
      w_div_nxt = r_div;
      if (w_sel_chg) begin
         w_off_nxt = '0;
         w_div_nxt = '0;
      end else if (SCROLL && scroll_en) begin
         if (r_div == DIV_W'(SCROLL_DIV - 1)) begin
            w_div_nxt = '0;
            if (r_off == OFF_W'(MAXOFF)) begin
               w_off_nxt = '0;
            end else begin
               w_off_nxt = r_off + OFF_W'(1);
            end
         end else begin
            w_div_nxt = r_div + DIV_W'(1);
         end
      end
   end

   // Word to display and decimal point pattern.
   always_comb begin
      if (w_state_nxt == S_HELD || w_state_nxt == S_FROZEN) begin
         w_word = w_hold_nxt;
      end else begin
         w_word = w_src;
      end
      w_dp_nxt    = '1;
      w_dp_nxt[0] = ~w_valid_nxt;
      if (int'(w_off_nxt) < MAXOFF) begin
         w_dp_nxt[NUM_DIGITS-1] = 1'b0;
      end
   end

   hex_window_select #(
      .SRC_W      (SRC_W),
      .NUM_DIGITS (NUM_DIGITS),
      .OFF_W      (OFF_W)
   ) u_win (
      .i_word   (w_word),
      .i_offset (w_off_nxt),
      .o_digits (w_digits)
   );

   // State, counters and registered outputs.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_LIVE;
         r_hold  <= '0;
         r_edge  <= 1'b0;
         r_sel   <= '0;
         r_off   <= '0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_hex   <= '0;
         r_dp    <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_edge  <= w_stb;
         r_sel   <= sel;
         r_off   <= w_off_nxt;
         r_div   <= w_div_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_valid_nxt;
         r_hex   <= w_digits;
         r_dp    <= w_dp_nxt;
      end
   end

   assign hex_digits    = r_hex;
   assign dp_n          = r_dp;
   assign capture_valid = r_valid;
   assign capture_count = r_cnt;

endmodule

// File: tb/tb_debug_hex_capture.sv
// Bench for debug_hex_capture: directed cases plus random
// stimulus against a behavioural model.
module tb_debug_hex_capture;

   localparam int SDIV = 4;
   localparam int MAXC = 3;
   localparam int MAXO = 2;

   logic         Clk = 1'b0;
   logic         Reset_n = 1'b0;
   logic [255:0] src_data = '0;
   logic [7:0]   src_strobe = '0;
   logic [2:0]   sel = '0;
   logic [1:0]   mode = '0;
   logic         scroll_en = 1'b0;
   logic [23:0]  hex_digits;
   logic [5:0]   dp_n;
   logic         capture_valid;
   logic [1:0]   capture_count;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   debug_hex_capture #(
      .NUM_SRC    (8),
      .SRC_W      (32),
      .NUM_DIGITS (6),
      .SCROLL_DIV (SDIV),
      .CNT_W      (2)
   ) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .src_data      (src_data),
      .src_strobe    (src_strobe),
      .sel           (sel),
      .mode          (mode),
      .scroll_en     (scroll_en),
      .hex_digits    (hex_digits),
      .dp_n          (dp_n),
      .capture_valid (capture_valid),
      .capture_count (capture_count)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: last mode seen, whether a capture is held,
   // and scroll progress as a plain count of enabled cycles.
   int          m_prev_mode = 0;
   bit          m_has = 1'b0;
   logic [31:0] m_hold = '0;
   int          m_cnt = 0;
   bit          m_prev_lvl = 1'b0;
   int          m_prev_sel = 0;
   int          m_ticks = 0;
   int          m_eff, m_off;
   logic [31:0] m_cur, m_word;
   bit          m_lvl, m_chg, m_rise, m_show;
   logic [23:0] exp_hex = '0;
   logic [5:0]  exp_dp = '1;
   logic        exp_valid = 1'b0;
   logic [1:0]  exp_cnt = '0;

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_prev_mode = 0;
         m_has       = 1'b0;
         m_hold      = '0;
         m_cnt       = 0;
         m_prev_lvl  = 1'b0;
         m_prev_sel  = 0;
         m_ticks     = 0;
         exp_hex     = '0;
         exp_dp      = '1;
         exp_valid   = 1'b0;
         exp_cnt     = '0;
      end else begin
         m_eff  = (mode == 2'd3) ? 0 : int'(mode);
         m_cur  = src_data[sel*32 +: 32];
         m_lvl  = src_strobe[sel];
         m_chg  = (int'(sel) != m_prev_sel);
         m_rise = m_lvl && !m_prev_lvl;
         if (m_eff == 0) begin
            m_has = 1'b0;
         end else if (m_eff == 2) begin
            if (m_prev_mode != 2) m_hold = m_cur;
            m_has = 1'b0;
         end else begin
            if (m_prev_mode != 1 || m_chg) begin
               m_has = 1'b0;
            end else if (m_rise) begin
               m_hold = m_cur;
               m_has  = 1'b1;
               if (m_cnt < MAXC) m_cnt++;
            end
         end
         if (m_chg) m_cnt = 0;
         if (m_chg) m_ticks = 0;
         else if (scroll_en) m_ticks++;
         m_prev_mode = m_eff;
         m_prev_lvl  = m_lvl;
         m_prev_sel  = int'(sel);
         m_off  = (m_ticks / SDIV) % (MAXO + 1);
         m_show = (m_eff == 2) || (m_eff == 1 && m_has);
         m_word = m_show ? m_hold : m_cur;
         exp_hex   = 24'(m_word >> (4 * m_off));
         exp_valid = (m_eff == 1) && m_has;
         exp_cnt   = 2'(m_cnt);
         exp_dp    = '1;
         if (exp_valid) exp_dp[0] = 1'b0;
         if (m_off < MAXO) exp_dp[5] = 1'b0;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge Clk) begin
      if (chk_en) begin
         chk("model_hex", 32'(hex_digits), 32'(exp_hex));
         chk("model_dp", 32'(dp_n), 32'(exp_dp));
         chk("model_valid", 32'(capture_valid), 32'(exp_valid));
         chk("model_cnt", 32'(capture_count), 32'(exp_cnt));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic set_src(input int i, input logic [31:0] v);
      src_data[i*32 +: 32] = v;
   endtask

   initial begin
      // T1: reset with random inputs
      for (int i = 0; i < 8; i++) set_src(i, $urandom);
      src_strobe = 8'($urandom);
      sel        = 3'($urandom);
      mode       = 2'($urandom);
      scroll_en  = 1'b1;
      cyc(3);
      chk_en = 1'b1;
      chk("rst_hex", 32'(hex_digits), 32'h0);
      chk("rst_dp", 32'(dp_n), 32'h3F);
      chk("rst_valid", 32'(capture_valid), 32'h0);
      chk("rst_cnt", 32'(capture_count), 32'h0);
      src_data   = '0;
      src_strobe = '0;
      sel        = 3'd0;
      mode       = 2'd0;
      scroll_en  = 1'b0;
      Reset_n    = 1'b1;
      cyc();

      // T2: live view
      sel = 3'd2;
      set_src(2, 32'hDEAD_BEEF);
      cyc();
      chk("live_hex", 32'(hex_digits), 32'h00AD_BEEF);
      chk("live_dp", 32'(dp_n), 32'h1F);

      // T3: capture on strobe, then source changes
      mode = 2'd1;
      sel  = 3'd0;
      set_src(0, 32'h0000_1234);
      cyc();
      chk("armed_hex", 32'(hex_digits), 32'h0000_1234);
      chk("armed_valid", 32'(capture_valid), 32'h0);
      src_strobe[0] = 1'b1;
      cyc();
      set_src(0, 32'h0000_5678);
      src_strobe[0] = 1'b0;
      cyc();
      chk("cap_hex", 32'(hex_digits), 32'h0000_1234);
      chk("cap_valid", 32'(capture_valid), 32'h1);
      chk("cap_cnt", 32'(capture_count), 32'h1);
      chk("cap_dp", 32'(dp_n), 32'h1E);

      // T4: strobe already high at sel change, and simultaneous edge
      src_strobe[1] = 1'b1;
      cyc();
      sel = 3'd1;
      cyc();
      chk("race1_cnt", 32'(capture_count), 32'h0);
      chk("race1_valid", 32'(capture_valid), 32'h0);
      cyc();
      chk("race1b_cnt", 32'(capture_count), 32'h0);
      src_strobe[1] = 1'b0;
      cyc();
      sel = 3'd2;
      src_strobe[2] = 1'b1;
      cyc();
      chk("race2_cnt", 32'(capture_count), 32'h0);
      chk("race2_valid", 32'(capture_valid), 32'h0);
      cyc();
      chk("race2b_cnt", 32'(capture_count), 32'h0);
      src_strobe = '0;

      // T5: scrolling window
      mode = 2'd0;
      sel  = 3'd3;
      set_src(3, 32'h8765_4321);
      scroll_en = 1'b1;
      cyc();
      chk("scr0_hex", 32'(hex_digits), 32'h0065_4321);
      chk("scr0_dp", 32'(dp_n), 32'h1F);
      cyc(4);
      chk("scr1_hex", 32'(hex_digits), 32'h0076_5432);
      chk("scr1_dp", 32'(dp_n), 32'h1F);
      cyc(4);
      chk("scr2_hex", 32'(hex_digits), 32'h0087_6543);
      chk("scr2_dp", 32'(dp_n), 32'h3F);
      cyc(4);
      chk("scrw_hex", 32'(hex_digits), 32'h0065_4321);

      // T6: freeze, then counter saturation
      scroll_en = 1'b0;
      sel  = 3'd4;
      set_src(4, 32'h00AB_CDEF);
      mode = 2'd2;
      cyc();
      chk("frz_hex", 32'(hex_digits), 32'h00AB_CDEF);
      set_src(4, 32'h1111_1111);
      cyc();
      chk("frz2_hex", 32'(hex_digits), 32'h00AB_CDEF);
      mode = 2'd1;
      cyc();
      for (int i = 0; i < 5; i++) begin
         src_strobe[4] = 1'b1;
         cyc();
         src_strobe[4] = 1'b0;
         cyc();
      end
      chk("sat_cnt", 32'(capture_count), 32'h3);
      chk("sat_valid", 32'(capture_valid), 32'h1);
      chk("sat_hex", 32'(hex_digits), 32'h0011_1111);

      // Random phase, with one asynchronous reset mid-run
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if ($urandom_range(39) == 0) mode = 2'($urandom);
         if ($urandom_range(29) == 0) sel = 3'($urandom);
         src_strobe = src_strobe ^
            (8'($urandom) & 8'($urandom) & 8'($urandom));
         if ($urandom_range(4) == 0) set_src($urandom_range(7), $urandom);
         if ($urandom_range(49) == 0) scroll_en = ~scroll_en;
         if (i == 1500) begin
            Reset_n = 1'b0;
            #1;
            chk("arst_hex", 32'(hex_digits), 32'h0);
            chk("arst_dp", 32'(dp_n), 32'h3F);
            cyc(2);
            Reset_n = 1'b1;
         end
      end
      cyc();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
